// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Contents:
//   arb_state_t   arbiter ownership state (IDLE, LOCK0, LOCK1)
//   LOCK_MAX_DEF  default limit on consecutive granted cycles of a locked owner
//   is_aligned()  word-alignment test on the two low byte-address bits
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam int LOCK_MAX_DEF = 15;

    function automatic logic is_aligned(input logic [1:0] i_lo);
        return (i_lo == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and an external data memory.
// Handshake: reqK acts as "valid" for requester K's transaction (we/lock/addr/
// wdata qualify it); gntK is the combinational "ready". A transaction transfers
// in exactly the cycle where reqK & gntK are both high. The requester may change
// or drop its request in any cycle; nothing has to be held after gntK=0. The
// response (rvalidK with rdataK/errK) is a single-cycle pulse one cycle later.
// Modports:
//   slave  - arbiter side (takes requests and mem_rdata, drives grants, responses, memory port)
//   master - environment side (requesters plus the data memory)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req0,   req1;
    logic              we0,    we1;
    logic              lock0,  lock1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0,   err1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin select.
// Ports:
//   i_req0/i_req1  request lines
//   i_prio         port that wins when both request
//   o_valid        at least one request present
//   o_sel          selected port (0/1); 0 when nothing requests
module rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_valid,
    output logic o_sel
);
    assign o_valid = i_req0 | i_req1;
    // A lone requester wins outright; a tie goes to the priority port.
    assign o_sel   = (i_req0 & i_req1) ? i_prio : i_req1;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin priority and bounded locking.
// Drives an external single-port data memory (combinational read, write on edge).
// Ports:
//   clock        single clock, rising edge
//   reset_       synchronous active-low reset
//   bus          dmem_arbiter_if.slave: requests, grants, responses, memory port
//   o_dbg_state  current ownership state
//   o_dbg_prio   port favoured on the next tie in IDLE
//   o_dbg_cnt    granted-cycle count of the current locked owner
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    localparam int CNT_W   = $clog2(LOCK_MAX + 1)
) (
    input  logic             clock,
    input  logic             reset_,
    dmem_arbiter_if.slave    bus,
    output arb_state_t       o_dbg_state,
    output logic             o_dbg_prio,
    output logic [CNT_W-1:0] o_dbg_cnt
);
    arb_state_t        r_state, w_state_nxt;
    logic              r_prio,  w_prio_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              w_pick_vld, w_pick_sel;
    logic              w_gnt0, w_gnt1;
    logic              w_misal0, w_misal1;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              r_rvalid0, r_rvalid1, r_err0, r_err1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    rr_pick u_rr_pick (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_prio  (r_prio),
        .o_valid (w_pick_vld),
        .o_sel   (w_pick_sel)
    );

    assign w_misal0 = ~is_aligned(bus.addr0[1:0]);
    assign w_misal1 = ~is_aligned(bus.addr1[1:0]);

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_gnt0 = ~w_pick_sel;
                    w_gnt1 = w_pick_sel;
                    if (w_pick_sel ? bus.lock1 : bus.lock0) begin
                        // Locked grant: priority only moves when the lock ends.
                        w_state_nxt = w_pick_sel ? ST_LOCK1 : ST_LOCK0;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_prio_nxt = ~w_pick_sel;
                    end
                end
            end
            ST_LOCK0: begin
                w_gnt0    = bus.req0;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Count reaching LOCK_MAX this cycle ends the lock even if still asked.
                if (!bus.lock0 || (r_cnt >= CNT_W'(LOCK_MAX - 1))) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK1: begin
                w_gnt1    = bus.req1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!bus.lock1 || (r_cnt >= CNT_W'(LOCK_MAX - 1))) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // No transaction may be accepted while reset is held.
        if (!reset_) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_addr  = bus.addr0;
            w_mem_wdata = bus.wdata0;
            w_mem_we    = bus.we0 & ~w_misal0;
        end else if (w_gnt1) begin
            w_mem_addr  = bus.addr1;
            w_mem_wdata = bus.wdata1;
            w_mem_we    = bus.we1 & ~w_misal1;
        end
    end

    // Responses: one-cycle pulses; read data captured from memory at the grant edge.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_err0    <= w_gnt0 & w_misal0;
            r_err1    <= w_gnt1 & w_misal1;
            r_rdata0  <= (w_gnt0 & ~bus.we0 & ~w_misal0) ? bus.mem_rdata : '0;
            r_rdata1  <= (w_gnt1 & ~bus.we1 & ~w_misal1) ? bus.mem_rdata : '0;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.err0      = r_err0;
    assign bus.err1      = r_err1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

    assign o_dbg_state = r_state;
    assign o_dbg_prio  = r_prio;
    assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: external 16x32 data memory, an abstract ownership
// model (owner / held count / priority) with a per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 15;
    localparam int CNT_W    = $clog2(LOCK_MAX + 1);

    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic reset_ = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    arb_state_t       dbg_state;
    logic             dbg_prio;
    logic [CNT_W-1:0] dbg_cnt;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock       (clock),
        .reset_      (reset_),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_prio  (dbg_prio),
        .o_dbg_cnt   (dbg_cnt)
    );

    // ---------------- external data memory ----------------
    logic [31:0] mem [16];
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner = -1;   // -1: free, else locked owner
    int          m_held  = 0;    // granted cycles of the locked owner so far
    int          m_prio  = 0;
    bit          exp_rv  [2];
    bit          exp_err [2];
    logic [31:0] exp_rd  [2];
    logic [31:0] shadow  [16];
    bit          chk_en  = 1'b0;

    task automatic model_step();
        int          g;
        bit          rq [2];
        bit          wq [2];
        bit          lk [2];
        logic [5:0]  ad [2];
        logic [31:0] wd [2];
        bit          al;
        bit          e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        arb_state_t  e_state;
        rq[0] = bus.req0;  rq[1] = bus.req1;
        wq[0] = bus.we0;   wq[1] = bus.we1;
        lk[0] = bus.lock0; lk[1] = bus.lock1;
        ad[0] = bus.addr0; ad[1] = bus.addr1;
        wd[0] = bus.wdata0; wd[1] = bus.wdata1;

        if (!reset_)               g = -1;
        else if (m_owner >= 0)     g = rq[m_owner] ? m_owner : -1;
        else if (rq[0] && rq[1])   g = m_prio;
        else if (rq[0])            g = 0;
        else if (rq[1])            g = 1;
        else                       g = -1;

        al = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (g >= 0) begin
            al      = (ad[g][1:0] == 2'b00);
            e_we    = wq[g] && al;
            e_addr  = ad[g];
            e_wdata = wd[g];
        end
        e_state = (m_owner < 0) ? ST_IDLE : ((m_owner == 0) ? ST_LOCK0 : ST_LOCK1);

        check1("gnt0", bus.gnt0, g == 0);
        check1("gnt1", bus.gnt1, g == 1);
        check1("single_grant", bus.gnt0 & bus.gnt1, 1'b0);
        check1("mem_we", bus.mem_we, e_we);
        check32("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        check32("mem_wdata", bus.mem_wdata, e_wdata);
        check1("rvalid0", bus.rvalid0, exp_rv[0]);
        check1("rvalid1", bus.rvalid1, exp_rv[1]);
        check1("err0", bus.err0, exp_err[0]);
        check1("err1", bus.err1, exp_err[1]);
        check32("rdata0", bus.rdata0, exp_rd[0]);
        check32("rdata1", bus.rdata1, exp_rd[1]);
        check32("state", 32'(dbg_state), 32'(e_state));
        check1("prio", dbg_prio, m_prio[0]);
        check32("lock_cnt", 32'(dbg_cnt), 32'(m_held));

        // advance to the next edge
        if (!reset_) begin
            m_owner = -1; m_held = 0; m_prio = 0;
            for (int k = 0; k < 2; k++) begin
                exp_rv[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_rv[k]  = (g == k);
                exp_err[k] = (g == k) && !al;
                exp_rd[k]  = ((g == k) && !wq[k] && al) ? shadow[ad[k][5:2]] : 32'd0;
            end
            if (e_we) shadow[e_addr[5:2]] = e_wdata;
            if (m_owner < 0) begin
                if (g >= 0) begin
                    if (lk[g]) begin m_owner = g; m_held = 1; end
                    else m_prio = 1 - g;
                end
            end else begin
                m_held++;
                if (!lk[m_owner] || m_held >= LOCK_MAX) begin
                    m_prio = 1 - m_owner; m_owner = -1; m_held = 0;
                end
            end
        end
    endtask

    always @(negedge clock) begin
        #3;
        if (chk_en) model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic drive0(input bit we, input bit lk, input logic [5:0] a, input logic [31:0] d);
        bus.req0 = 1; bus.we0 = we; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic drive1(input bit we, input bit lk, input logic [5:0] a, input logic [31:0] d);
        bus.req1 = 1; bus.we1 = we; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
    endtask

    // ---------------- stimulus ----------------
    int run_len;
    int first_g1;
    bit in_run;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 32'hC0DE_0000 | 32'(i);
            shadow[i] = 32'hC0DE_0000 | 32'(i);
        end
        idle_inputs();
        reset_ = 0;
        chk_en = 1;

        // reset: requests are ignored while reset_ is low
        cyc(); drive0(1, 0, 6'd0, 32'h1111_1111);
        #4 check1("lit_rst_gnt0", bus.gnt0, 1'b0);
        check1("lit_rst_mem_we", bus.mem_we, 1'b0);
        cyc(); idle_inputs();
        #4 check1("lit_rst_rvalid0", bus.rvalid0, 1'b0);
        check32("lit_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check1("lit_rst_prio", dbg_prio, 1'b0);

        // two reads from reset: port0 first, then port1
        cyc(); reset_ = 1; drive0(0, 0, 6'd8, '0); drive1(0, 0, 6'd12, '0);
        #4 check1("lit_both_gnt0", bus.gnt0, 1'b1);
        cyc();
        #4 check1("lit_both_gnt1", bus.gnt1, 1'b1);
        check32("lit_rdata0_w2", bus.rdata0, 32'hC0DE_0002);
        cyc(); idle_inputs();
        #4 check1("lit_rvalid1", bus.rvalid1, 1'b1);
        check32("lit_rdata1_w3", bus.rdata1, 32'hC0DE_0003);

        // write then read back through the other port
        cyc(); drive0(1, 0, 6'd4, 32'hA5A5_A5A5);
        #4 check1("lit_wr_mem_we", bus.mem_we, 1'b1);
        cyc(); idle_inputs(); drive1(0, 0, 6'd4, '0);
        #4 check1("lit_rd_gnt1", bus.gnt1, 1'b1);
        cyc(); idle_inputs();
        #4 check32("lit_rdback", bus.rdata1, 32'hA5A5_A5A5);

        // lock held for 20 cycles against continuous competition
        run_len = 0; first_g1 = -1; in_run = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(); drive0(0, 1, 6'd0, '0); drive1(0, 0, 6'd16, '0);
            #4;
            if (in_run && bus.gnt0) run_len++;
            else in_run = 0;
            if (first_g1 < 0 && bus.gnt1) first_g1 = i;
        end
        check32("lit_lock_run", 32'(run_len), 32'd15);
        check32("lit_lock_first_g1", 32'(first_g1), 32'd15);
        cyc(); idle_inputs();
        cyc();

        // misaligned write from port1
        cyc(); drive1(1, 0, 6'd6, 32'hDEAD_BEEF);
        #4 check1("lit_mis_gnt1", bus.gnt1, 1'b1);
        check1("lit_mis_mem_we", bus.mem_we, 1'b0);
        cyc(); idle_inputs();
        #4 check1("lit_mis_err1", bus.err1, 1'b1);
        check32("lit_mis_rdata1", bus.rdata1, 32'd0);
        check32("lit_word4_kept", mem[1], 32'hA5A5_A5A5);

        // reset while port1 holds a lock with a read outstanding
        cyc(); drive0(0, 0, 6'd0, '0);
        cyc(); idle_inputs(); drive1(0, 1, 6'd12, '0);
        #4 check1("lit_prio_before", dbg_prio, 1'b1);
        cyc(); drive1(0, 1, 6'd8, '0);
        #4 check32("lit_lock1_state", 32'(dbg_state), 32'(ST_LOCK1));
        cyc(); idle_inputs(); reset_ = 0;
        cyc(); reset_ = 1;
        #4 check1("lit_rst_drop_rvalid1", bus.rvalid1, 1'b0);
        check32("lit_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
        check1("lit_rst_prio0", dbg_prio, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int lk_pct;
            cyc();
            lk_pct = ((i / 200) % 2 == 1) ? 95 : 30;
            reset_    = ($urandom_range(0, 99) != 0);
            bus.req0  = ($urandom_range(0, 3) != 0);
            bus.req1  = ($urandom_range(0, 3) != 0);
            bus.we0   = $urandom_range(0, 1) == 1;
            bus.we1   = $urandom_range(0, 1) == 1;
            bus.lock0 = ($urandom_range(0, 99) < lk_pct);
            bus.lock1 = ($urandom_range(0, 99) < lk_pct);
            bus.addr0 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : {4'($urandom_range(0, 15)), 2'b00};
            bus.addr1 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : {4'($urandom_range(0, 15)), 2'b00};
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
        end
        cyc(); idle_inputs(); reset_ = 1;
        cyc();
        cyc();
        chk_en = 0;
        #4;
        for (int i = 0; i < 16; i++) check32("mem_contents", mem[i], shadow[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, byte-address width of the data memory (16 words x 32 bits).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LOCK_MAX, default 15, maximum consecutive granted cycles of one locked owner.
REQ-004 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset_  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-006 Ports req0/req1  input  1  requester k has a transaction this cycle.
REQ-007 Ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 Ports lock0/lock1  input  1  requester k asks to keep ownership after this transaction.
REQ-009 Ports addr0/addr1  input  ADDR_W  byte address.
REQ-010 Ports wdata0/wdata1  input  DATA_W  write data.
REQ-011 Ports gnt0/gnt1  output  1  transaction accepted this cycle (combinational).
REQ-012 Ports rvalid0/rvalid1  output  1  response for k's accepted transaction, one cycle after gnt.
REQ-013 Ports rdata0/rdata1  output  DATA_W  registered read data, valid with rvalid.
REQ-014 Ports err0/err1  output  1  misaligned access response, valid with rvalid.
REQ-015 Port mem_we  output  1  write enable to data memory.
REQ-016 Port mem_addr  output  ADDR_W  address to data memory.
REQ-017 Port mem_wdata  output  DATA_W  write data to data memory.
REQ-018 Port mem_rdata  input  DATA_W  combinational read data from data memory.

Function
REQ-019 States IDLE, LOCK0, LOCK1; at most one of gnt0/gnt1 high per cycle.
REQ-020 IDLE: single requester granted; both requesting -> grant port indicated by prio bit; no request -> no grant, mem_we=0.
REQ-021 After an unlocked grant to port k, prio <= other port; no grant -> prio unchanged.
REQ-022 Grant to k with lock_k=1 in IDLE -> next state LOCKk, lock counter <= 1.
REQ-023 LOCKk: only port k may be granted; other port's gnt=0 regardless of req.
REQ-024 LOCKk exit to IDLE at end of any cycle with lock_k=0; prio <= other port.
REQ-025 LOCKk: counter increments per cycle; when it reaches LOCK_MAX, forced exit to IDLE, prio <= other port, even if lock_k=1.
REQ-026 mem_addr/mem_wdata mux from granted port; no grant -> mem_addr=0, mem_wdata=0.
REQ-027 mem_we = gnt_k & we_k & aligned, where aligned = addr_k[1:0]==0.
REQ-028 Read latency: rvalid_k rises the cycle after gnt_k; rdata_k = mem_rdata captured at the grant edge.
REQ-029 Write response: rvalid_k pulses the cycle after gnt_k, rdata_k=0, write already committed at the grant edge.
REQ-030 Misaligned access: still granted, mem_we=0, next cycle rvalid_k=1, err_k=1, rdata_k=0.
REQ-031 rvalid/err are single-cycle pulses; back-to-back grants give back-to-back pulses.
REQ-032 Requester may change req/addr/we any cycle; no hold required after gnt=0.

Reset
REQ-033 reset_=0 at a rising edge -> state IDLE, prio=0, counter=0, all rvalid/err=0, rdata=0.
REQ-034 Reset mid-lock or with a pending response drops the response; no rvalid after reset.
REQ-035 While reset_=0, gnt0=gnt1=0 and mem_we=0.

Structure
REQ-036 State encoding and LOCK_MAX default SHALL live in shared package dmem_pkg.
REQ-037 Block SHALL instantiate no memory; it drives an external dataMemory-compatible port.
REQ-038 Optional sub-module rr_pick (two-way round-robin priority select); no others.

Verification
REQ-039 Both req (read, addr0=8, addr1=12) from reset -> gnt0 first, then gnt1; rvalid follows each by one cycle with memory contents.
REQ-040 req0 write addr=4 wdata=0xA5A5A5A5, next cycle req1 read addr=4 -> rdata1=0xA5A5A5A5.
REQ-041 req0 lock0=1 held 20 cycles, req1 continuous -> gnt0 for exactly 15 cycles, then gnt1 granted.
REQ-042 req1 write addr=6 -> gnt1=1, mem_we=0, next cycle err1=1, rdata1=0; word 4 unchanged.
REQ-043 reset_=0 during LOCK1 with read pending -> next cycle IDLE, rvalid1=0, prio=0.
REQ-044 Bench SHALL model dataMemory (16x32, word index addr[5:2]) and check at most one grant per cycle.
